// File: rtl/sdm_pkg.sv
// Shared constants and helpers for the delta-sigma CIC demodulator.
// The localparams below describe the default build (D_W=16, CIC_N=3,
// DEC_LOG2=6); the top derives its own widths from its parameters through
// the same functions, so both always agree.
package sdm_pkg;

    localparam int D_W_DEF      = 16;
    localparam int CIC_N_DEF    = 3;
    localparam int DEC_LOG2_DEF = 6;

    // Integrator/comb width: CIC gain is R^N = 2^(N*log2R), plus sign and
    // one bit of headroom so +R^N itself is representable.
    function automatic int calc_acc_w(input int cic_n, input int dec_log2);
        return cic_n * dec_log2 + 2;
    endfunction

    // Right shift that maps the CIC gain onto the D_W output range.
    function automatic int calc_shift(input int cic_n, input int dec_log2, input int d_w);
        return cic_n * dec_log2 - (d_w - 1);
    endfunction

    function automatic longint sat_max_f(input int d_w);
        return (longint'(1) << (d_w - 1)) - 1;
    endfunction

    function automatic longint sat_min_f(input int d_w);
        return -(longint'(1) << (d_w - 1));
    endfunction

    localparam int ACC_W = calc_acc_w(CIC_N_DEF, DEC_LOG2_DEF);
    localparam int S     = calc_shift(CIC_N_DEF, DEC_LOG2_DEF, D_W_DEF);

    typedef logic signed [ACC_W-1:0] acc_t;

    // Bitstream mapping: 1 -> +1, 0 -> -1 (2-bit signed, sign-extend on use).
    localparam logic signed [1:0] BIT_POS = 2'sb01;
    localparam logic signed [1:0] BIT_NEG = 2'sb11;

    localparam logic signed [D_W_DEF-1:0] SAT_MAX = D_W_DEF'(sat_max_f(D_W_DEF));
    localparam logic signed [D_W_DEF-1:0] SAT_MIN = D_W_DEF'(sat_min_f(D_W_DEF));

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb (differentiator) stage. The delay register holds the previous
// decimated input and advances only when a new sample is loaded, so the stage
// runs at the decimated rate while being clocked at the full rate.
module cic_comb_stage #(
    parameter int W = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] dout,
    output logic                vld
);

    logic signed [W-1:0] dly;

    // Differentiate on each load strobe; strobe follows the data by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly  <= '0;
            dout <= '0;
            vld  <= 1'b0;
        end else begin
            vld <= ld;
            if (ld) begin
                dout <= din - dly;
                dly  <= din;
            end
        end
    end

endmodule

// File: rtl/sdm_cic_demod.sv
// First-order delta-sigma bitstream demodulator: CIC_N integrators at the
// bit rate, decimation by 2^DEC_LOG2, CIC_N comb stages, shift and clip to a
// signed D_W sample. The first CIC_N+1 results after reset are discarded while
// the comb delay lines fill.
// Optional macro SDM_DMOD_SYNC_EN: passes dmod_din (and en alongside it, so
// the whole datapath shifts uniformly by two clocks) through a 2-flop
// synchronizer for use with an asynchronous external comparator.
module sdm_cic_demod
    import sdm_pkg::*;
#(
    parameter int D_W      = 16,
    parameter int CIC_N    = 3,
    parameter int DEC_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dmod_din,
    output logic signed [D_W-1:0] dmod_dout,
    output logic                  dmod_valid,
    output logic                  dmod_sat
);

    localparam int CIC_ACC_W = calc_acc_w(CIC_N, DEC_LOG2);
    localparam int CIC_S     = calc_shift(CIC_N, DEC_LOG2, D_W);
    localparam logic signed [D_W:0] SAT_HI = (D_W+1)'(sat_max_f(D_W));
    localparam logic signed [D_W:0] SAT_LO = (D_W+1)'(sat_min_f(D_W));
    localparam logic [2:0] WARM_LEN = 3'(CIC_N + 1);

    // Scaled comb output always fits in D_W+1 bits: ACC_W - S == D_W + 1.
    function automatic logic signed [D_W:0] scale_acc(input logic signed [CIC_ACC_W-1:0] c);
        logic signed [CIC_ACC_W-1:0] sh;
        sh = c >>> CIC_S;
        return sh[D_W:0];
    endfunction

    function automatic logic signed [D_W-1:0] sat_val(input logic signed [D_W:0] v);
        if (v > SAT_HI)
            return SAT_HI[D_W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[D_W-1:0];
        else
            return v[D_W-1:0];
    endfunction

    function automatic logic is_clip(input logic signed [D_W:0] v);
        return (v > SAT_HI) || (v < SAT_LO);
    endfunction

    logic din_q;
    logic en_q;

`ifdef SDM_DMOD_SYNC_EN
    logic [1:0] din_sync;
    logic [1:0] en_sync;

    // Two-flop input synchronizer; en is delayed with the data so each bit is
    // still integrated under its own enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_sync <= '0;
            en_sync  <= '0;
        end else begin
            din_sync <= {din_sync[0], dmod_din};
            en_sync  <= {en_sync[0], en};
        end
    end

    assign din_q = din_sync[1];
    assign en_q  = en_sync[1];
`else
    assign din_q = dmod_din;
    assign en_q  = en;
`endif

    logic signed [CIC_ACC_W-1:0] x_ext;
    assign x_ext = din_q ? {{(CIC_ACC_W-2){BIT_POS[1]}}, BIT_POS}
                         : {{(CIC_ACC_W-2){BIT_NEG[1]}}, BIT_NEG};

    for (genvar k = 0; k < CIC_N; k++) begin : g_integ
        logic signed [CIC_ACC_W-1:0] acc;
        logic signed [CIC_ACC_W-1:0] addend;

        if (k == 0) begin : g_first
            assign addend = x_ext;
        end else begin : g_next
            assign addend = g_integ[k-1].acc;
        end

        // Pipelined integrator, modular wrap is intentional.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                acc <= '0;
            else if (en_q)
                acc <= acc + addend;
        end
    end

    logic [DEC_LOG2-1:0] dec_cnt;
    logic                capture;
    assign capture = en_q && (&dec_cnt);

    // Decimation counter, advances only on enabled bit cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dec_cnt <= '0;
        else if (en_q)
            dec_cnt <= dec_cnt + 1'b1;
    end

    // ---- stage p0: capture last integrator at the decimated rate ----
    logic signed [CIC_ACC_W-1:0] cap_p0;
    logic                        vld_p0;

    // Latch I_N on the capture edge and launch the comb pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_p0 <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= capture;
            if (capture)
                cap_p0 <= g_integ[CIC_N-1].acc;
        end
    end

    // ---- stages p1..pN: comb chain, one stage per clock ----
    logic signed [CIC_ACC_W-1:0] comb_d [CIC_N+1];
    logic                        comb_v [CIC_N+1];

    assign comb_d[0] = cap_p0;
    assign comb_v[0] = vld_p0;

    for (genvar k = 0; k < CIC_N; k++) begin : g_comb
        cic_comb_stage #(.W(CIC_ACC_W)) u_comb (
            .clk  (clk),
            .rst  (rst),
            .ld   (comb_v[k]),
            .din  (comb_d[k]),
            .dout (comb_d[k+1]),
            .vld  (comb_v[k+1])
        );
    end

    // ---- output stage: scale, clip, warm-up gating ----
    logic signed [D_W:0] scaled;
    logic                res_v;
    logic [2:0]          warm_cnt;
    logic                warm_done;

    assign scaled    = scale_acc(comb_d[CIC_N]);
    assign res_v     = comb_v[CIC_N];
    assign warm_done = (warm_cnt == WARM_LEN);

    // Register the clipped sample; during warm-up results are counted but
    // neither presented nor allowed to touch the sticky clip flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_cnt   <= '0;
            dmod_valid <= 1'b0;
            dmod_dout  <= '0;
            dmod_sat   <= 1'b0;
        end else begin
            dmod_valid <= res_v && warm_done;
            if (res_v) begin
                if (!warm_done) begin
                    warm_cnt <= warm_cnt + 3'd1;
                end else begin
                    dmod_dout <= sat_val(scaled);
                    if (is_clip(scaled))
                        dmod_sat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdm_cic_demod.sv
// Directed bench for sdm_cic_demod (defaults D_W=16, CIC_N=3, DEC_LOG2=6).
module tb_sdm_cic_demod;

`ifdef SDM_DMOD_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    // 5th capture (first unsuppressed) at enabled edge 320, output 4 clocks later.
    localparam int FIRST = 324 + LAT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic dmod_din = 1'b0;
    logic signed [15:0] dmod_dout;
    logic dmod_valid;
    logic dmod_sat;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int ph = 0;
    int hold_bad = 0;
    int st_edge[$];
    logic signed [15:0] st_val[$];

    always #5 clk = ~clk;

    sdm_cic_demod #(.D_W(16), .CIC_N(3), .DEC_LOG2(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dmod_din   (dmod_din),
        .dmod_dout  (dmod_dout),
        .dmod_valid (dmod_valid),
        .dmod_sat   (dmod_sat)
    );

    task automatic clear_log();
        edge_n = 0;
        ph = 0;
        hold_bad = 0;
        st_edge.delete();
        st_val.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        dmod_din = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
    endtask

    // Drive ncyc clocks of a 4-bit repeating pattern; en is low for the edges
    // numbered off_at+1 .. off_at+off_len. Pattern advances only on en cycles.
    task automatic run(input int ncyc, input logic [3:0] pat, input int off_at, input int off_len);
        for (int i = 0; i < ncyc; i++) begin
            en = !(edge_n >= off_at && edge_n < off_at + off_len);
            dmod_din = pat[ph];
            @(posedge clk);
            #1;
            edge_n++;
            if (en) ph = (ph + 1) % 4;
            if (dmod_valid) begin
                st_edge.push_back(edge_n);
                st_val.push_back(dmod_dout);
            end else if (st_val.size() == 0) begin
                if (dmod_dout !== 16'sd0) hold_bad++;
            end else if (dmod_dout !== st_val[st_val.size()-1]) begin
                hold_bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dmod_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", dmod_valid); end
        total++;
        if (dmod_dout !== 16'sd0) begin bad++; $display("FAIL reset_dout got %0d want 0", dmod_dout); end
        total++;
        if (dmod_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got %0b want 0", dmod_sat); end
    endtask

    task automatic test_steady(input string name, input logic [3:0] pat,
                               input logic signed [15:0] exp_val, input logic exp_sat);
        do_reset();
        run(456, pat, 0, 0);
        total++;
        if (st_edge.size() !== 3) begin
            bad++; $display("FAIL %s strobe_count got %0d want 3", name, st_edge.size());
        end
        for (int i = 0; i < st_edge.size() && i < 3; i++) begin
            total++;
            if (st_edge[i] !== FIRST + 64 * i) begin
                bad++; $display("FAIL %s strobe%0d_edge got %0d want %0d", name, i, st_edge[i], FIRST + 64 * i);
            end
            total++;
            if (st_val[i] !== exp_val) begin
                bad++; $display("FAIL %s strobe%0d_value got %0d want %0d", name, i, st_val[i], exp_val);
            end
        end
        total++;
        if (dmod_sat !== exp_sat) begin bad++; $display("FAIL %s sat got %0b want %0b", name, dmod_sat, exp_sat); end
        total++;
        if (hold_bad !== 0) begin bad++; $display("FAIL %s dout_hold glitches got %0d want 0", name, hold_bad); end
    endtask

    // Runs straight on from the constant-high stream (dout=32767, sat=1).
    task automatic test_reset_mid();
        run(514 + LAT - edge_n, 4'b1111, 0, 0);
        rst = 1'b1;
        #1;
        total++;
        if (dmod_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got %0b want 0", dmod_valid); end
        total++;
        if (dmod_dout !== 16'sd0) begin bad++; $display("FAIL rstmid_dout got %0d want 0", dmod_dout); end
        total++;
        if (dmod_sat !== 1'b0) begin bad++; $display("FAIL rstmid_sat got %0b want 0", dmod_sat); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        run(400, 4'b1111, 0, 0);
        total++;
        if (st_edge.size() !== 2) begin bad++; $display("FAIL rstmid_strobe_count got %0d want 2", st_edge.size()); end
        if (st_edge.size() > 0) begin
            total++;
            if (st_edge[0] !== FIRST) begin bad++; $display("FAIL rstmid_first_edge got %0d want %0d", st_edge[0], FIRST); end
        end
    endtask

    task automatic test_en_gap();
        int exp_e[5];
        exp_e = '{324 + LAT, 388 + LAT, 552 + LAT, 616 + LAT, 680 + LAT};
        do_reset();
        run(700, 4'b0111, 400, 100);
        total++;
        if (st_edge.size() !== 5) begin bad++; $display("FAIL engap_strobe_count got %0d want 5", st_edge.size()); end
        for (int i = 0; i < st_edge.size() && i < 5; i++) begin
            total++;
            if (st_edge[i] !== exp_e[i]) begin
                bad++; $display("FAIL engap strobe%0d_edge got %0d want %0d", i, st_edge[i], exp_e[i]);
            end
            total++;
            if (st_val[i] !== 16'sd16384) begin
                bad++; $display("FAIL engap strobe%0d_value got %0d want 16384", i, st_val[i]);
            end
        end
        total++;
        if (hold_bad !== 0) begin bad++; $display("FAIL engap dout_hold glitches got %0d want 0", hold_bad); end
    endtask

    initial begin
        test_reset();
        test_steady("const_high", 4'b1111, 16'sd32767, 1'b1);
        test_reset_mid();
        test_steady("const_low", 4'b0000, -16'sd32768, 1'b0);
        test_steady("alternate", 4'b0101, 16'sd0, 1'b0);
        test_steady("density75", 4'b0111, 16'sd16384, 1'b0);
        test_steady("density25", 4'b1000, -16'sd16384, 1'b0);
        test_en_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
